matrix_stream_loader: RTL and testbench

Parametrised RMII-side matrix loader: deserialises a 2-bit-per-cycle Ethernet payload stream into NUM_MATS back-to-back row-major matrices, packs each row into a wide word and writes it into on-chip row storage. Each row write is announced as it lands, and a registered random-access read port serves any stored row to the compute array. Framing errors are detected, and an optional trailing checksum is verified. The block sits between the Ethernet receive path and the matrix-multiply datapath, in the eth_refclk domain.

---
 rtl/matrix_stream_loader.sv | 217 +++++++++++++++++++++
 tb/tb_matrix_stream_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// RMII dibit stream to row-major matrix storage with row-write notification and a registered read port.
// Optional trailing 8-bit checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module matrix_stream_loader #(
   parameter  int ELEMENT_WIDTH = 8,
   parameter  int ROWS          = 32,
   parameter  int COLS          = 32,
   parameter  int NUM_MATS      = 2,
   localparam int MW            = (NUM_MATS > 1) ? $clog2(NUM_MATS) : 1,
   localparam int RW            = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int WW            = COLS * ELEMENT_WIDTH
) (
   input  logic          eth_refclk,
   input  logic          rst_n,
   input  logic          axiiv,
   input  logic [1:0]    axiid,
   input  logic          rd_req,
   input  logic [MW-1:0] rd_mat,
   input  logic [RW-1:0] rd_row,
   output logic          rd_valid,
   output logic [WW-1:0] rd_data,
   output logic          row_wr_valid,
   output logic [MW-1:0] row_wr_mat,
   output logic [RW-1:0] row_wr_row,
   output logic          busy,
   output logic          complete,
   output logic          err
);

   localparam int DPE   = ELEMENT_WIDTH / 2;
   localparam int DW    = (DPE > 1) ? $clog2(DPE) : 1;
   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DEPTH = NUM_MATS * ROWS;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
`ifdef LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE,
      ERROR,
      DRAIN
   } state_t;

   state_t        state;
   logic          axiiv_q;
   logic [DW-1:0] dib_cnt;
   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;
   logic [MW-1:0] mat_cnt;
   logic [WW-1:0] row_sh;
   logic [WW-1:0] mem [DEPTH];

   logic          last_dib, last_col, last_row, last_mat;
   logic          row_done, frame_done;
   logic          start, consume, wr_en;
   logic [WW-1:0] nxt_word;
   logic [AW-1:0] wr_addr, rd_addr;

   always_comb begin
      last_dib   = (dib_cnt == DW'(DPE - 1));
      last_col   = (col_cnt == CW'(COLS - 1));
      last_row   = (row_cnt == RW'(ROWS - 1));
      last_mat   = (mat_cnt == MW'(NUM_MATS - 1));
      row_done   = last_dib && last_col;
      frame_done = row_done && last_row && last_mat;
      // A frame may only start on a rising axiiv once a previous frame has ended.
      start      = axiiv && ((state == IDLE) ||
                             (((state == DONE) || (state == ERROR)) && !axiiv_q));
      consume    = axiiv && ((state == LOAD) || start);
      wr_en      = consume && row_done;
      nxt_word   = (row_sh << 2) | WW'(axiid);
      wr_addr    = AW'(int'(mat_cnt) * ROWS + int'(row_cnt));
      rd_addr    = AW'(int'(rd_mat) * ROWS + int'(rd_row));
   end

   always_ff @(posedge eth_refclk) begin
      if (wr_en) mem[wr_addr] <= nxt_word;
   end

   always_ff @(posedge eth_refclk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) rd_data <= mem[rd_addr];
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] acc;
   logic [7:0] chk_sh;
   logic [1:0] chk_cnt;
   logic [7:0] elem_lo;
   logic [7:0] chk_word;

   always_comb begin
      elem_lo  = 8'(nxt_word[ELEMENT_WIDTH-1:0]);
      chk_word = {chk_sh[5:0], axiid};
   end

   always_ff @(posedge eth_refclk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         chk_sh  <= '0;
         chk_cnt <= '0;
      end else begin
         if (start)                    acc <= last_dib ? elem_lo : '0;
         else if (consume && last_dib) acc <= acc + elem_lo;
         if (state == CHECK && axiiv) begin
            chk_sh  <= chk_word;
            chk_cnt <= chk_cnt + 2'd1;
         end else begin
            chk_cnt <= '0;
         end
      end
   end
`endif

   always_ff @(posedge eth_refclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         axiiv_q      <= 1'b0;
         dib_cnt      <= '0;
         col_cnt      <= '0;
         row_cnt      <= '0;
         mat_cnt      <= '0;
         row_sh       <= '0;
         row_wr_valid <= 1'b0;
         row_wr_mat   <= '0;
         row_wr_row   <= '0;
         busy         <= 1'b0;
         complete     <= 1'b0;
         err          <= 1'b0;
      end else begin
         axiiv_q      <= axiiv;
         row_wr_valid <= wr_en;
         if (wr_en) begin
            row_wr_mat <= mat_cnt;
            row_wr_row <= row_cnt;
         end
         if (consume) begin
            row_sh <= nxt_word;
            if (!last_dib) dib_cnt <= dib_cnt + DW'(1);
            else begin
               dib_cnt <= '0;
               if (!last_col) col_cnt <= col_cnt + CW'(1);
               else begin
                  col_cnt <= '0;
                  if (!last_row) row_cnt <= row_cnt + RW'(1);
                  else begin
                     row_cnt <= '0;
                     mat_cnt <= last_mat ? '0 : mat_cnt + MW'(1);
                  end
               end
            end
         end
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  complete <= 1'b0;
                  err      <= 1'b0;
               end else if (axiiv) begin
                  state <= DRAIN;
               end
            end
            LOAD: begin
               if (!axiiv) begin
                  // Partial row is dropped: counters restart for the next frame.
                  state   <= ERROR;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  dib_cnt <= '0;
                  col_cnt <= '0;
                  row_cnt <= '0;
                  mat_cnt <= '0;
               end else if (frame_done) begin
`ifdef LOADER_CHECKSUM_EN
                  state    <= CHECK;
`else
                  state    <= DONE;
                  busy     <= 1'b0;
                  complete <= 1'b1;
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               if (!axiiv) begin
                  state <= ERROR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else if (chk_cnt == 2'd3) begin
                  busy <= 1'b0;
                  if (chk_word == acc) begin
                     state    <= DONE;
                     complete <= 1'b1;
                  end else begin
                     state <= ERROR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            DRAIN: begin
               if (!axiiv) state <= complete ? DONE : ERROR;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader (EW=8, 4x4, two matrices) with a frame-level reference model.
module tb_matrix_stream_loader;

`ifdef LOADER_CHECKSUM_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam int PAYLOAD = 128;
   localparam int TOTAL   = CHK ? 132 : 128;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        axiiv = 1'b0;
   logic [1:0]  axiid = '0;
   logic        rd_req = 1'b0;
   logic [0:0]  rd_mat = '0;
   logic [1:0]  rd_row = '0;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        row_wr_valid;
   logic [0:0]  row_wr_mat;
   logic [1:0]  row_wr_row;
   logic        busy, complete, err;

   int total = 0;
   int bad   = 0;
   int wr_seen = 0;

   always #5 clk = ~clk;

   matrix_stream_loader #(
      .ELEMENT_WIDTH(8), .ROWS(4), .COLS(4), .NUM_MATS(2)
   ) dut (
      .eth_refclk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid),
      .rd_req(rd_req), .rd_mat(rd_mat), .rd_row(rd_row),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .row_wr_valid(row_wr_valid), .row_wr_mat(row_wr_mat), .row_wr_row(row_wr_row),
      .busy(busy), .complete(complete), .err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame-level view of storage, status and expected pulses.
   logic [31:0] mem_m [8];
   bit          known [8];
   int          mode = 0;   // 0 ready for a frame, 1 loading, 2 waiting for axiiv low
   int          k = 0;
   logic [31:0] buf_m;
   logic [7:0]  acc_m, chk_m;
   logic        exp_busy = 0, exp_complete = 0, exp_err = 0;
   logic        exp_rdv = 0, exp_rdk = 0, exp_wrv = 0;
   logic [31:0] exp_rdd = '0;
   int          exp_wrm = 0, exp_wrr = 0;

   initial begin
      for (int i = 0; i < 8; i++) known[i] = 1'b0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mode = 0; exp_busy = 0; exp_complete = 0; exp_err = 0;
            exp_rdv = 0; exp_wrv = 0;
         end else begin
            exp_wrv = 0;
            exp_rdv = rd_req;
            if (rd_req) begin
               exp_rdk = known[int'(rd_mat) * 4 + int'(rd_row)];
               exp_rdd = mem_m[int'(rd_mat) * 4 + int'(rd_row)];
            end
            if (mode == 0 && axiiv) begin
               mode = 1; k = 0; acc_m = 0; chk_m = 0;
               exp_busy = 1; exp_complete = 0; exp_err = 0;
            end else if (mode == 1 && !axiiv) begin
               mode = 0; exp_busy = 0; exp_err = 1;
            end else if (mode == 2 && !axiiv) begin
               mode = 0;
            end
            if (mode == 1 && axiiv) begin
               if (k < PAYLOAD) begin
                  buf_m = {buf_m[29:0], axiid};
                  if (k % 4 == 3) acc_m = acc_m + buf_m[7:0];
                  if (k % 16 == 15) begin
                     mem_m[k / 16] = buf_m;
                     known[k / 16] = 1'b1;
                     exp_wrv = 1; exp_wrm = (k / 16) / 4; exp_wrr = (k / 16) % 4;
                  end
               end else begin
                  chk_m = {chk_m[5:0], axiid};
               end
               k++;
               if (k == TOTAL) begin
                  mode = 2; exp_busy = 0;
                  if (CHK && chk_m != acc_m) exp_err = 1;
                  else exp_complete = 1;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("complete", 32'(complete), 32'(exp_complete));
            check("err", 32'(err), 32'(exp_err));
            check("rd_valid", 32'(rd_valid), 32'(exp_rdv));
            check("row_wr_valid", 32'(row_wr_valid), 32'(exp_wrv));
            if (row_wr_valid) wr_seen++;
            if (exp_wrv) begin
               check("row_wr_mat", 32'(row_wr_mat), 32'(exp_wrm));
               check("row_wr_row", 32'(row_wr_row), 32'(exp_wrr));
            end
            if (exp_rdv && exp_rdk) check("rd_data", rd_data, exp_rdd);
         end
      end
   end

   task automatic build(input logic [7:0] base, input bit trailer, input int delta,
                        output logic [1:0] dq [$]);
      logic [7:0] v, s;
      dq = {};
      s = 0;
      for (int e = 0; e < 32; e++) begin
         v = base + 8'(e);
         s = s + v;
         dq.push_back(v[7:6]); dq.push_back(v[5:4]);
         dq.push_back(v[3:2]); dq.push_back(v[1:0]);
      end
      if (trailer) begin
         s = s + 8'(delta);
         dq.push_back(s[7:6]); dq.push_back(s[5:4]);
         dq.push_back(s[3:2]); dq.push_back(s[1:0]);
      end
   endtask

   task automatic send_frame(input logic [7:0] base, input bit trailer, input int delta,
                             input int drop_after, input int extra, input int ra, input int rb,
                             output logic [31:0] cap_a, output logic [31:0] cap_b);
      logic [1:0] dq [$];
      int nsend;
      build(base, trailer, delta, dq);
      nsend = (drop_after >= 0) ? drop_after : dq.size();
      cap_a = '0; cap_b = '0;
      for (int j = 0; j < nsend + extra; j++) begin
         @(negedge clk);
         if (j == ra + 1) cap_a = rd_data;
         if (j == rb + 1) cap_b = rd_data;
         if (extra > 0 && j == nsend + extra - 1) begin
            check("drain_busy", 32'(busy), 32'h0);
            check("drain_complete", 32'(complete), 32'h1);
         end
         rd_req = (j == ra) || (j == rb);
         rd_mat = '0; rd_row = 2'd1;
         axiiv = 1'b1;
         axiid = (j < nsend) ? dq[j] : 2'b11;
      end
      @(negedge clk);
      axiiv = 1'b0; rd_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_read(input int m, input int r, output logic [31:0] d);
      @(negedge clk);
      rd_req = 1'b1; rd_mat = 1'(m); rd_row = 2'(r);
      @(negedge clk);
      rd_req = 1'b0;
      d = rd_data;
   endtask

   initial begin
      logic [31:0] ca, cb, d;
      logic [1:0]  dq [$];

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_complete", 32'(complete), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_rd_valid", 32'(rd_valid), 32'h0);
      check("rst_row_wr_valid", 32'(row_wr_valid), 32'h0);
      check("rst_rd_data", rd_data, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      send_frame(8'h40, CHK, 0, -1, 0, -10, -10, ca, cb);
      check("f1_complete", 32'(complete), 32'h1);

      wr_seen = 0;
      send_frame(8'h00, CHK, 0, -1, 0, 31, 32, ca, cb);
      check("wr_pulses", 32'(wr_seen), 32'd8);
      check("model_checksum", 32'(acc_m), 32'h0000_00F0);
      check("rd_before_write", ca, 32'h4445_4647);
      check("rd_during_wr_valid", cb, 32'h0405_0607);
      check("full_complete", 32'(complete), 32'h1);
      check("full_err", 32'(err), 32'h0);
      do_read(1, 2, d);
      check("read_m1_r2", d, 32'h1819_1A1B);

      send_frame(8'h00, CHK, 0, -1, 6, -10, -10, ca, cb);
      check("overrun_complete", 32'(complete), 32'h1);
      do_read(0, 0, d);
      check("overrun_m0_r0", d, 32'h0001_0203);

      send_frame(8'h80, CHK, 0, 37, 0, -10, -10, ca, cb);
      check("abort_err", 32'(err), 32'h1);
      check("abort_complete", 32'(complete), 32'h0);
      do_read(0, 0, d);
      check("abort_m0_r0", d, 32'h8081_8283);
      do_read(0, 1, d);
      check("abort_m0_r1", d, 32'h8485_8687);
      do_read(0, 2, d);
      check("abort_m0_r2", d, 32'h0809_0A0B);

      send_frame(8'h00, CHK, 0, -1, 0, -10, -10, ca, cb);
      check("recover_err", 32'(err), 32'h0);
      check("recover_complete", 32'(complete), 32'h1);

      wr_seen = 0;
      send_frame(8'h10, 1'b1, 1, -1, 0, -10, -10, ca, cb);
      check("cks_pulses", 32'(wr_seen), 32'd8);
      check("cks_err", 32'(err), CHK ? 32'h1 : 32'h0);
      check("cks_complete", 32'(complete), CHK ? 32'h0 : 32'h1);
      do_read(1, 3, d);
      check("cks_m1_r3", d, 32'h2C2D_2E2F);

      build(8'h20, CHK, 0, dq);
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         axiiv = 1'b1; axiid = dq[j];
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_complete", 32'(complete), 32'h0);
      check("arst_err", 32'(err), 32'h0);
      check("arst_rd_valid", 32'(rd_valid), 32'h0);
      check("arst_row_wr_valid", 32'(row_wr_valid), 32'h0);
      check("arst_rd_data", rd_data, 32'h0);
      axiiv = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send_frame(8'h00, CHK, 0, -1, 0, -10, -10, ca, cb);
      check("post_rst_complete", 32'(complete), 32'h1);
      do_read(0, 2, d);
      check("post_rst_m0_r2", d, 32'h0809_0A0B);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
